ps2_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, typematic, ...) to a keyboard over the same open-drain clock/data pair the keyboard receiver listens on. It runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit and device ACK. It reports completion, ACK status and timeout. It sits beside the keyboard receiver and is driven by the keyboard controller logic.

---
 rtl/ps2_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Runs the host request sequence (clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop, device ACK) over the open-drain clock/data pair.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a device-silence timeout
// that aborts the transfer and pulses err; without it err is tied low and
// the block waits indefinitely for the device.
module ps2_tx #(
  parameter int unsigned INHIBIT = 2800,
  parameter int unsigned TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire  [1:0] ps2,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack,
  output logic       err
);

  if (INHIBIT == 0 || INHIBIT > 65535 || TIMEOUT == 0 || TIMEOUT > 65535) begin : g_param_check
    $error("ps2_tx: INHIBIT and TIMEOUT must be in 1..65535");
  end

  localparam logic [15:0] INH_LAST = 16'(INHIBIT - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t      state, state_n;
  logic [15:0] count, count_n;   // inhibit length, reused as timeout counter
  logic [9:0]  frame, frame_n;   // {stop, parity, data[7:0]}
  logic [3:0]  idx, idx_n;       // next frame bit to drive in BITS
  logic        dq, dq_n;         // data level driven in BITS (1 = released)
  logic        ack_q, ack_n;
  logic        done_q, done_n;
`ifdef PS2_TX_TIMEOUT_EN
  logic        err_q, err_n;
`endif

  // Line filter and data sampler
  logic [7:0]  filt;
  logic        fclk;             // filtered PS/2 clock
  logic        fe;               // one-cycle falling-edge event of fclk
  logic        sd;               // registered PS/2 data

  // Shift the raw clock into the filter, track the filtered level, flag its falling edge.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values, matching the synthesized flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      fclk <= 1'b1;
      fe   <= 1'b0;
      sd   <= 1'b0;
    end else begin
      filt <= {filt[6:0], ps2[0]};
      if (filt == 8'hFF) begin
        fclk <= 1'b1;
      end else if (filt == 8'h00) begin
        fclk <= 1'b0;
      end
      fe <= fclk && (filt == 8'h00);
      sd <= ps2[1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      count  <= '0;
      frame  <= '0;
      idx    <= '0;
      dq     <= 1'b1;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      count  <= count_n;
      frame  <= frame_n;
      idx    <= idx_n;
      dq     <= dq_n;
      ack_q  <= ack_n;
      done_q <= done_n;
`ifdef PS2_TX_TIMEOUT_EN
      err_q  <= err_n;
`endif
    end
  end

  // Next-state and datapath update for the host request sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_n = state;
    count_n = count;
    frame_n = frame;
    idx_n   = idx;
    dq_n    = dq;
    ack_n   = ack_q;
    done_n  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    err_n   = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          frame_n = {1'b1, ~^data, data};
          count_n = '0;
          ack_n   = 1'b0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (count == INH_LAST) begin
          count_n = '0;
          state_n = S_REQ;
        end else begin
          count_n = count + 16'd1;
        end
      end
      S_REQ: begin
        if (fe) begin
          dq_n    = frame[0];
          idx_n   = 4'd1;
          state_n = S_BITS;
        end
      end
      S_BITS: begin
        if (fe) begin
          dq_n  = frame[idx];
          idx_n = idx + 4'd1;
          if (idx == 4'd9) begin
            state_n = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          ack_n   = ~sd;
          state_n = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (fclk && sd) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Device-silence watchdog: any device clock edge reloads it.
    if ((state inside {S_REQ, S_BITS, S_ACK, S_WAITIDLE}) && !done_n) begin
      if (fe) begin
        count_n = '0;
      end else if (count == TO_LAST) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end else begin
        count_n = count + 16'd1;
      end
    end
`endif
  end

  // Open-drain drivers decoded from the registered state, so reset releases
  // both lines immediately.
  logic clk_low, data_low;
  assign clk_low  = (state == S_INHIBIT);
  assign data_low = ((state == S_INHIBIT) && (count == INH_LAST)) ||
                    (state == S_REQ) ||
                    ((state == S_BITS) && !dq);

  assign ps2[0] = clk_low  ? 1'b0 : 1'bz;
  assign ps2[1] = data_low ? 1'b0 : 1'bz;

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign ack  = ack_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule
